vga_scanout: RTL and testbench

- Downstream display stage of the camera pipeline.
- Generates standard 640x480@60 VGA timing from the 25 MHz system clock.
- Pulls RGB565 pixels from a valid/ready stream (line/frame buffer output) and drives the VGA DAC pins with registered, aligned sync, blank and 8-bit colour.
- Owns frame alignment via a start-of-frame marker, and detects and recovers from underflow and misalignment.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_timing_gen.sv | 69 ++++++
 rtl/vga_scanout.sv | 136 +++++++++++++
 tb/tb_vga_scanout.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, scan-out state type and RGB565 colour expansion.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef enum logic {
        WAIT_SOF,
        RUN
    } scan_state_t;

    // MSB replication so full-scale 565 maps to full-scale 888.
    function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] pix);
        return {pix[15:11], pix[15:13], pix[10:5], pix[10:9], pix[4:0], pix[4:2]};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with sync, active and origin decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic active_o,
    output logic hs_n_o,
    output logic vs_n_o,
    output logic origin_o
);

    localparam int unsigned HTot = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTot = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One extra count of headroom so every boundary constant fits the counter width.
    localparam int unsigned HW   = $clog2(HTot + 1);
    localparam int unsigned VW   = $clog2(VTot + 1);

    localparam logic [HW-1:0] HLast  = HW'(HTot - 1);
    localparam logic [HW-1:0] HAct   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HsBeg  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HsEnd  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VLast  = VW'(VTot - 1);
    localparam logic [VW-1:0] VAct   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VsBeg  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VsEnd  = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;

    // Next raster position: hcnt wraps every line, vcnt steps on that wrap.
    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == HLast) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Decode of the current raster position.
    always_comb begin
        active_o = (hcnt_q < HAct) && (vcnt_q < VAct);
        hs_n_o   = !((hcnt_q >= HsBeg) && (hcnt_q < HsEnd));
        vs_n_o   = !((vcnt_q >= VsBeg) && (vcnt_q < VsEnd));
        origin_o = (hcnt_q == '0) && (vcnt_q == '0);
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: pixel-stream handshake FSM, status flags and the single output register stage.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pix_data,
    input  logic        pix_sof,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        frame_start,
    output logic        underflow,
    output logic        resync,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_n,
    output logic        VGA_SYNC_n,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    logic active, hs_n, vs_n, origin;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i    (clk),
        .rst_i    (reset),
        .active_o (active),
        .hs_n_o   (hs_n),
        .vs_n_o   (vs_n),
        .origin_o (origin)
    );

    scan_state_t state_q, state_d;
    logic        show;
    logic        resync_d;
    logic        uf_set;
    logic        hs_q, vs_q, blank_n_q, uf_q, resync_q, fs_q;
    logic [23:0] rgb_q;

    // Handshake FSM: next state, ready, display strobe and status events.
    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        show      = 1'b0;
        resync_d  = 1'b0;
        uf_set    = 1'b0;
        if (!reset) begin
            unique case (state_q)
                WAIT_SOF: begin
                    // Drain non-SOF words; hold an SOF word until the raster origin.
                    if (pix_valid && pix_sof) begin
                        if (origin) begin
                            pix_ready = 1'b1;
                            show      = 1'b1;
                            state_d   = RUN;
                        end
                    end else begin
                        pix_ready = 1'b1;
                    end
                end
                RUN: begin
                    if (active) begin
                        pix_ready = 1'b1;
                        if (!pix_valid) begin
                            // Slot is lost, not stretched.
                            uf_set = 1'b1;
                        end else if (pix_sof != origin) begin
                            // SOF off-origin, or missing SOF at origin: leave the word queued.
                            pix_ready = 1'b0;
                            resync_d  = 1'b1;
                            state_d   = WAIT_SOF;
                        end else begin
                            show = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Output register stage and status flags; underflow set beats the frame-start clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT_SOF;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
            uf_q      <= 1'b0;
            resync_q  <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            hs_q      <= hs_n;
            vs_q      <= vs_n;
            blank_n_q <= active;
            rgb_q     <= show ? rgb565_to_rgb888(pix_data) : '0;
            uf_q      <= uf_set | (uf_q & ~origin);
            resync_q  <= resync_d;
            fs_q      <= origin;
        end
    end

    assign VGA_CLK     = clk;
    assign VGA_SYNC_n  = 1'b1;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_n = blank_n_q;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign underflow   = uf_q;
    assign resync      = resync_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench: a reduced-timing instance for stream behaviour, a default instance for line timing.
module tb_vga_scanout;

    // Reduced raster: 16 clocks/line (8 visible), 8 lines/frame (4 visible), 128 clocks/frame.
    localparam int HT = 16;
    localparam int VT = 8;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready, frame_start, underflow, resync;
    logic        vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
    logic [7:0]  vga_r, vga_g, vga_b;

    logic [15:0] d_data;
    logic        d_sof, d_valid;
    logic        d_ready, d_fs, d_uf, d_resync;
    logic        d_clk, d_hs, d_vs, d_blank_n, d_sync_n;
    logic [7:0]  d_r, d_g, d_b;

    always #20 clk = ~clk;

    vga_scanout #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut (
        .clk (clk), .reset (reset), .pix_data (pix_data), .pix_sof (pix_sof),
        .pix_valid (pix_valid), .pix_ready (pix_ready), .frame_start (frame_start),
        .underflow (underflow), .resync (resync), .VGA_CLK (vga_clk), .VGA_HS (vga_hs),
        .VGA_VS (vga_vs), .VGA_BLANK_n (vga_blank_n), .VGA_SYNC_n (vga_sync_n),
        .VGA_R (vga_r), .VGA_G (vga_g), .VGA_B (vga_b)
    );

    vga_scanout dut_d (
        .clk (clk), .reset (reset), .pix_data (d_data), .pix_sof (d_sof),
        .pix_valid (d_valid), .pix_ready (d_ready), .frame_start (d_fs),
        .underflow (d_uf), .resync (d_resync), .VGA_CLK (d_clk), .VGA_HS (d_hs),
        .VGA_VS (d_vs), .VGA_BLANK_n (d_blank_n), .VGA_SYNC_n (d_sync_n),
        .VGA_R (d_r), .VGA_G (d_g), .VGA_B (d_b)
    );

    typedef struct {
        logic [15:0] data;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } vec_t;

    vec_t        tbl[7];
    logic [16:0] q[$];
    int          total = 0;
    int          passed = 0;
    logic        gap, rdy, fire;

    task automatic chk(input string name, input int c, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare every output of both instances for raster cycle c.
    task automatic check_outputs(input int c);
        int f, cf, h, v, slot, hd, vd;
        logic vis;
        logic [23:0] exp_rgb;
        f    = c / FT;
        cf   = c % FT;
        h    = c % HT;
        v    = (c / HT) % VT;
        vis  = (h < 8) && (v < 4);
        slot = v * 8 + h;
        exp_rgb = 24'h0;
        if (vis) begin
            case (f)
                1, 4: exp_rgb = {tbl[slot % 7].r, tbl[slot % 7].g, tbl[slot % 7].b};
                2: if (slot < 10 || slot > 14)
                       exp_rgb = {tbl[slot % 7].r, tbl[slot % 7].g, tbl[slot % 7].b};
                3: if (slot <= 10)
                       exp_rgb = {tbl[slot % 7].r, tbl[slot % 7].g, tbl[slot % 7].b};
                default: exp_rgb = 24'h0;
            endcase
        end
        chk("blank_n", c, 32'(vga_blank_n), 32'(vis));
        chk("hs", c, 32'(vga_hs), 32'(!(h >= 10 && h < 13)));
        chk("vs", c, 32'(vga_vs), 32'(!(v >= 5 && v < 7)));
        chk("rgb", c, 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
        chk("frame_start", c, 32'(frame_start), 32'(cf == 0));
        chk("underflow", c, 32'(underflow), 32'((f == 2 && cf >= 18) || f >= 5));
        chk("resync", c, 32'(resync), 32'(f == 3 && cf == 19));
        hd = c % 800;
        vd = (c / 800) % 525;
        chk("def_hs", c, 32'(d_hs), 32'(!(hd >= 656 && hd < 752)));
        chk("def_blank_n", c, 32'(d_blank_n), 32'(hd < 640 && vd < 480));
        chk("def_vs", c, 32'(d_vs), 32'(1));
    endtask

    initial begin
        tbl[0] = '{16'hF800, 8'hFF, 8'h00, 8'h00};
        tbl[1] = '{16'h0841, 8'h08, 8'h08, 8'h08};
        tbl[2] = '{16'h07E0, 8'h00, 8'hFF, 8'h00};
        tbl[3] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[4] = '{16'h001F, 8'h00, 8'h00, 8'hFF};
        tbl[5] = '{16'h8410, 8'h84, 8'h82, 8'h84};
        tbl[6] = '{16'h5555, 8'h52, 8'hAA, 8'hAD};

        reset = 1'b1;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 16'h0;
        d_valid = 1'b0; d_sof = 1'b0; d_data = 16'h0;
        repeat (3) tick();

        // Mid-line reset: run into the HS pulse, then reset with an SOF word presented.
        reset = 1'b0;
        repeat (12) tick();
        chk("pre_reset_hs", 11, 32'(vga_hs), 32'(0));
        chk("pre_reset_blank", 11, 32'(vga_blank_n), 32'(0));
        reset = 1'b1;
        pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 16'hFFFF;
        tick();
        #1;
        chk("rst_ready", 0, 32'(pix_ready), 32'(0));
        chk("rst_hs", 0, 32'(vga_hs), 32'(1));
        chk("rst_vs", 0, 32'(vga_vs), 32'(1));
        chk("rst_blank_n", 0, 32'(vga_blank_n), 32'(0));
        chk("rst_rgb", 0, 32'({vga_r, vga_g, vga_b}), 32'(0));
        chk("rst_underflow", 0, 32'(underflow), 32'(0));
        chk("rst_resync", 0, 32'(resync), 32'(0));
        chk("rst_frame_start", 0, 32'(frame_start), 32'(0));
        chk("rst_sync_n", 0, 32'(vga_sync_n), 32'(1));
        tick();
        pix_valid = 1'b0; pix_sof = 1'b0;

        // Stream: 3 junk words, full frame, frame with a 5-slot gap, truncated frame, full frame.
        q.push_back({1'b0, 16'h1234});
        q.push_back({1'b0, 16'h4321});
        q.push_back({1'b0, 16'hABCD});
        for (int fr = 1; fr <= 4; fr++) begin
            for (int i = 0; i < ((fr == 3) ? 11 : 32); i++)
                q.push_back({(i == 0), tbl[i % 7].data});
        end

        reset = 1'b0;
        for (int k = 0; k < 1700; k++) begin
            if (k > 0) check_outputs(k - 1);
            gap = (k / FT == 2) && (k % FT >= 18) && (k % FT <= 22);
            pix_valid = (q.size() > 0) && !gap;
            if (q.size() > 0) {pix_sof, pix_data} = q[0];
            else {pix_sof, pix_data} = 17'h0;
            #1;
            rdy  = pix_ready;
            fire = pix_valid && rdy;
            case (k)
                0, 1, 2, 128, 512, 640: chk("ready_hi", k, 32'(rdy), 32'(1));
                3, 127, 136, 3 * FT + 19: chk("ready_lo", k, 32'(rdy), 32'(0));
                default: ;
            endcase
            @(posedge clk);
            if ((fire || gap) && q.size() > 0) void'(q.pop_front());
            @(negedge clk);
        end
        chk("queue_drained", 1700, 32'(q.size()), 32'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
